// File: rtl/board_input_conditioner_pkg.sv
// Shared constants for the board input front-end: clock rate, default
// debounce window and the width of the processor-facing I/O word.
package board_io_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 1;
  localparam int unsigned IO_WORD_W   = 32;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);

endpackage

// File: rtl/board_input_conditioner_if.sv
// Pin/processor bundle for board_input_conditioner: raw board pins and the
// event-clear strobe in, conditioned levels, pulses, flags and I/O word out.
interface board_input_conditioner_if
  import board_io_pkg::*;
#(
    parameter int NUM_SW  = 18,
    parameter int NUM_KEY = 4
);
    logic [NUM_SW-1:0]    sw_raw_i;
    logic [NUM_KEY-1:0]   key_raw_i;
    logic [NUM_KEY-1:0]   event_clr_i;
    logic [NUM_SW-1:0]    sw_o;
    logic [NUM_KEY-1:0]   key_o;
    logic [NUM_KEY-1:0]   key_press_o;
    logic [NUM_KEY-1:0]   key_release_o;
    logic [NUM_KEY-1:0]   key_event_o;
    logic [IO_WORD_W-1:0] io_in_o;

    modport master (
        output sw_raw_i, key_raw_i, event_clr_i,
        input  sw_o, key_o, key_press_o, key_release_o, key_event_o, io_in_o
    );

    modport slave (
        input  sw_raw_i, key_raw_i, event_clr_i,
        output sw_o, key_o, key_press_o, key_release_o, key_event_o, io_in_o
    );
endinterface

// File: rtl/board_input_conditioner_debounce_cell.sv
// One input channel: multi-flop synchroniser, optional polarity inversion,
// saturating stability counter, debounced level and rise/fall strobes.
module debounce_cell #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int INVERT          = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_next_o
);
    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic           INV     = 1'(INVERT);

    if (SYNC_STAGES < 2)     begin : g_chk_sync  $error("SYNC_STAGES must be >= 2");     end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb   $error("DEBOUNCE_CYCLES must be >= 1"); end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    // Synchroniser resets to the released pin level, so held-active pins
    // are seen as a fresh transition once reset drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {SYNC_STAGES{INV}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INV;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign rise_next_o = rise_d;
endmodule

// File: rtl/board_input_conditioner.sv
// DE2 input front-end: debounces switches and keys, generates key press/release
// pulses and sticky press flags, and packs them into the processor I/O word.
module board_input_conditioner
  import board_io_pkg::*;
#(
    parameter int NUM_SW          = 18,
    parameter int NUM_KEY         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input logic                      clk_i,
    input logic                      rst_i,
    board_input_conditioner_if.slave io
);
    if (NUM_SW < 1 || NUM_SW > 31)   begin : g_chk_sw   $error("NUM_SW out of range");  end
    if (NUM_KEY < 1 || NUM_KEY > 31) begin : g_chk_key  $error("NUM_KEY out of range"); end
    if (NUM_SW + NUM_KEY > int'(IO_WORD_W)) begin : g_chk_w
        $error("NUM_SW + NUM_KEY exceeds the I/O word");
    end

    logic [NUM_SW-1:0]  sw_lvl;
    logic [NUM_SW-1:0]  sw_rise_unused, sw_fall_unused, sw_next_unused;
    logic [NUM_KEY-1:0] key_lvl, key_press, key_rel, key_rise_next;
    logic [NUM_KEY-1:0] key_event_q, key_event_d;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (0)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .raw_i      (io.sw_raw_i[i]),
            .level_o    (sw_lvl[i]),
            .rise_o     (sw_rise_unused[i]),
            .fall_o     (sw_fall_unused[i]),
            .rise_next_o(sw_next_unused[i])
        );
    end

    for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
        debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (KEY_ACTIVE_LOW)
        ) u_cell (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .raw_i      (io.key_raw_i[i]),
            .level_o    (key_lvl[i]),
            .rise_o     (key_press[i]),
            .fall_o     (key_rel[i]),
            .rise_next_o(key_rise_next[i])
        );
    end

    // Flag is set from the pre-register rise so it lands on the same edge as
    // the press pulse; set beats a simultaneous clear.
    always_comb begin
        key_event_d = (key_event_q & ~io.event_clr_i) | key_rise_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) key_event_q <= '0;
        else       key_event_q <= key_event_d;
    end

    always_comb begin
        io.io_in_o                   = '0;
        io.io_in_o[NUM_SW-1:0]       = sw_lvl;
        io.io_in_o[NUM_SW +: NUM_KEY] = key_event_q;
    end

    assign io.sw_o          = sw_lvl;
    assign io.key_o         = key_lvl;
    assign io.key_press_o   = key_press;
    assign io.key_release_o = key_rel;
    assign io.key_event_o   = key_event_q;
endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Parametrised input front-end for the DE2 board top level: synchronises and debounces NUM_SW slide switches and NUM_KEY push-buttons. It produces clean levels, one-cycle press/release pulses and sticky press-event flags. The result is packed into one 32-bit word that feeds the processor's switch I/O port in place of raw SW wiring. It sits between the board pins and the core, in the top-level wrapper.

## Interface
- NUM_SW, 18: number of slide-switch channels, 1..31.
- NUM_KEY, 4: number of push-button channels, 1..31. NUM_SW+NUM_KEY ≤ 32 is checked at elaboration.
- SYNC_STAGES, 2: flip-flops per synchroniser, ≥2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed before an output changes, ≥1. The default is 1 ms at 50 MHz.
- KEY_ACTIVE_LOW, 1: 1 means the raw key pin reads 0 when pressed.

Ports:
- clk_i  in  1  system clock (CLOCK_50).
- rst_i  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- sw_raw_i  in  NUM_SW  raw switch pins, asynchronous.
- key_raw_i  in  NUM_KEY  raw key pins, asynchronous, polarity per KEY_ACTIVE_LOW.
- event_clr_i  in  NUM_KEY  write-1-to-clear strobes for key_event_o.
- sw_o  out  NUM_SW  debounced switch levels.
- key_o  out  NUM_KEY  debounced key state, 1 = pressed.
- key_press_o  out  NUM_KEY  one-cycle pulse on a debounced press.
- key_release_o  out  NUM_KEY  one-cycle pulse on a debounced release.
- key_event_o  out  NUM_KEY  sticky flag, set on press, held until cleared.
- io_in_o  out  32  packed word {zeros, key_event_o, sw_o}; sw_o occupies bits [NUM_SW-1:0].

## Operation
- **Synchroniser.** Each channel passes through SYNC_STAGES flops, giving synchronised sample s.
- **Key polarity.** Key samples are inverted when KEY_ACTIVE_LOW=1, so that internally 1 = pressed.
- **Debounce counter.** Each channel has a counter cnt of width $clog2(DEBOUNCE_CYCLES+1) and a stable level q. On every edge:
  - If s == q: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: q ← s and cnt ← 0.
  - Else: cnt ← cnt+1.
- **Glitch rejection.** Any return of s to q before the count completes restarts the count from 0. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches q.
- **Press/release pulses.** key_press_o[i] is registered and asserted on the same edge that sets q from 0 to 1, for exactly one cycle. key_release_o[i] behaves the same way for the 1 to 0 transition.
- **Sticky event flag.** key_event_o[i] is set by press and cleared by event_clr_i[i]. If a press and a clear occur on the same edge, set wins (the flag stays 1). Clearing an already-clear flag has no effect.
- **Switches.** Switches have no pulses and no event flags.
- **Reset values (asynchronous):**
  - Synchroniser flops go to the released/low pin level: 0 for switches, KEY_ACTIVE_LOW for keys.
  - q = 0, cnt = 0.
  - sw_o, key_o, key_press_o, key_release_o, key_event_o and io_in_o are all 0.
- **Reset behaviour:**
  - A pin that is active while reset is held gives no pulse during reset.
  - After release, an active pin is debounced normally. The first qualified press therefore produces a press pulse and sets the event flag.
  - Reset asserted mid-count discards the count.

## Timing
- **Latency.** A raw change is first captured at edge 1. s updates at edge SYNC_STAGES. q, the pulse and the event flag update at edge SYNC_STAGES+DEBOUNCE_CYCLES. This holds provided the raw level stays stable for the whole interval.
- **DEBOUNCE_CYCLES=1.** q follows s with exactly one cycle of delay.
- **Combinational outputs.**
  - io_in_o is purely combinational from registered state, with no extra latency.
  - event_clr_i is the only input with a same-edge effect: the flag reads 0 in the next cycle.
- **Counter range.** The counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.

## Structure
- Package board_io_pkg holds:
  - CLK_HZ = 50_000_000.
  - DEBOUNCE_MS default and the derived default DEBOUNCE_CYCLES.
  - IO_WORD_W = 32.
- Sub-module debounce_cell covers one channel: synchroniser, counter, q and rise/fall strobes. Its parameters are SYNC_STAGES, DEBOUNCE_CYCLES and INVERT.
- The top level uses generate loops: NUM_SW instances with INVERT=0 and NUM_KEY instances with INVERT=KEY_ACTIVE_LOW. It adds the event flags and the io_in_o packing.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
1. **Reset.** Hold rst_i with key_raw_i=4'b1111 and sw_raw_i=18'h3FFFF → all outputs 0. After release, sw_o=18'h3FFFF at edge 6, io_in_o=32'h0003FFFF, and the keys remain 0.
2. **Clean press.** key_raw_i[0] 1→0 held → key_o[0]=1 and a key_press_o[0] pulse of exactly 1 cycle at edge 6, plus key_event_o[0]=1. io_in_o bit 18 = 1.
3. **Glitch rejection.** A 3-cycle low pulse on key_raw_i[1] → no change on any key output. A 4-cycle pulse does produce a press, then a release pulse 4 cycles after the pin returns.
4. **Event clearing.** Assert event_clr_i[0] for one cycle → key_event_o[0]=0 in the next cycle. Then assert event_clr_i[0] on the same edge as a key 0 press → key_event_o[0] stays 1.
5. **Reset mid-count.** Assert rst_i at edge 4 of a debounce count, release it with the pin still pressed → press occurs 6 edges after release, never earlier.
6. **Parametric build.** NUM_SW=10, NUM_KEY=2, KEY_ACTIVE_LOW=0 → io_in_o[11:10] = events and [31:12] = 0. An active-high key press is detected.
